// File: rtl/mem_stage_sram_pkg.sv
// Shared configuration for the memory stage: datapath width, SRAM word width
// and the encoding of the SRAM access FSM states.
package mem_stage_sram_pkg;

    localparam int CFG_ADDRESS_LEN = 32;
    localparam int SRAM_DW         = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

endpackage

// File: rtl/mem_stage_sram_sram_ctrl.sv
// SRAM access sequencer: splits one 32-bit access into a low and a high
// half-word phase, each held WAIT_STATES cycles, with registered strobes.
module sram_ctrl
    import mem_stage_sram_pkg::*;
#(
    parameter int WAIT_STATES = 5,
    parameter int SRAM_AW     = 18
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rd_i,
    input  logic                   wr_i,
    input  logic [SRAM_AW-2:0]     word_i,
    input  logic [2*SRAM_DW-1:0]   wdata_i,
    input  logic [SRAM_DW-1:0]     sram_rdata_i,
    output logic                   ready_o,
    output logic [2*SRAM_DW-1:0]   rdata32_o,
    output logic [SRAM_AW-1:0]     sram_addr_o,
    output logic [SRAM_DW-1:0]     sram_wdata_o,
    output logic                   sram_we_n_o,
    output logic                   sram_oe_n_o
);

    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(WAIT_STATES - 1);

    sram_state_e            state_q;
    logic [CW-1:0]          cnt_q;
    logic [SRAM_AW-1:0]     addr_q;
    logic [SRAM_DW-1:0]     wdata_q;
    logic                   we_n_q;
    logic                   oe_n_q;
    logic [2*SRAM_DW-1:0]   rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_i || wr_i) begin
                        state_q <= ST_LOW;
                        cnt_q   <= RELOAD;
                        addr_q  <= {word_i, 1'b0};
                        if (wr_i) begin
                            wdata_q <= wdata_i[SRAM_DW-1:0];
                            we_n_q  <= 1'b0;
                        end else begin
                            oe_n_q  <= 1'b0;
                        end
                    end
                end
                ST_LOW: begin
                    if (cnt_q == '0) begin
                        // Strobes stay asserted across the phase change; only address/data move.
                        if (!oe_n_q) rdata_q[SRAM_DW-1:0] <= sram_rdata_i;
                        if (!we_n_q) wdata_q <= wdata_i[2*SRAM_DW-1:SRAM_DW];
                        state_q <= ST_HIGH;
                        cnt_q   <= RELOAD;
                        addr_q  <= {addr_q[SRAM_AW-1:1], 1'b1};
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == '0) begin
                        if (!oe_n_q) rdata_q[2*SRAM_DW-1:SRAM_DW] <= sram_rdata_i;
                        state_q <= ST_DONE;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o      = ((state_q == ST_IDLE) && !(rd_i || wr_i)) || (state_q == ST_DONE);
    assign rdata32_o    = rdata_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_oe_n_o  = oe_n_q;

endmodule

// File: rtl/mem_stage_sram.sv
// ARM pipeline memory stage with MEM/WB register over a 16-bit SRAM.
// Optional address range check enabled by defining MEM_ADDR_CHECK_EN.
module mem_stage_sram
    import mem_stage_sram_pkg::*;
#(
    parameter int ADDRESS_LEN = CFG_ADDRESS_LEN,
    parameter int MEM_BASE    = 1024,
    parameter int WAIT_STATES = 5,
    parameter int SRAM_AW     = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDRESS_LEN-1:0] alu_res,
    input  logic [ADDRESS_LEN-1:0] val_rm,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic                   wb_en_in,
    input  logic [3:0]             dest_in,
    output logic                   ready,
    output logic [SRAM_AW-1:0]     sram_addr,
    output logic [SRAM_DW-1:0]     sram_wdata,
    input  logic [SRAM_DW-1:0]     sram_rdata,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
`ifdef MEM_ADDR_CHECK_EN
    output logic                   mem_err,
`endif
    output logic [ADDRESS_LEN-1:0] alu_res_out,
    output logic [ADDRESS_LEN-1:0] data_memory_out,
    output logic                   mem_r_en_out,
    output logic                   wb_en_out,
    output logic [3:0]             dest_out
);

    logic [ADDRESS_LEN-1:0] offset;
    logic                   acc_ok;
    logic                   rd_req;
    logic                   wr_req;
    logic [2*SRAM_DW-1:0]   rdata32;
    logic [ADDRESS_LEN-1:0] data_d;
    logic                   unused_offset;

    assign offset        = alu_res - ADDRESS_LEN'(MEM_BASE);
    assign unused_offset = ^offset;

`ifdef MEM_ADDR_CHECK_EN
    logic out_of_range;
    logic mem_err_q;

    assign out_of_range = (alu_res < ADDRESS_LEN'(MEM_BASE)) ||
                          (|offset[ADDRESS_LEN-1:SRAM_AW+1]);
    assign acc_ok       = ~out_of_range;

    always_ff @(posedge clk) begin
        if (rst) mem_err_q <= 1'b0;
        else     mem_err_q <= (mem_r_en | mem_w_en) & out_of_range;
    end
    assign mem_err = mem_err_q;
`else
    assign acc_ok = 1'b1;
`endif

    // A simultaneous read and write request is executed as a store.
    assign wr_req = mem_w_en & acc_ok;
    assign rd_req = mem_r_en & ~mem_w_en & acc_ok;

    sram_ctrl #(
        .WAIT_STATES (WAIT_STATES),
        .SRAM_AW     (SRAM_AW)
    ) u_sram_ctrl (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_i         (rd_req),
        .wr_i         (wr_req),
        .word_i       (offset[SRAM_AW:2]),
        .wdata_i      (val_rm[2*SRAM_DW-1:0]),
        .sram_rdata_i (sram_rdata),
        .ready_o      (ready),
        .rdata32_o    (rdata32),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_we_n_o  (sram_we_n),
        .sram_oe_n_o  (sram_oe_n)
    );

    assign data_d = rd_req ? ADDRESS_LEN'(rdata32) : '0;

    // MEM/WB register: loads on ready, otherwise inserts a bubble in the control bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_res_out     <= '0;
            data_memory_out <= '0;
            mem_r_en_out    <= 1'b0;
            wb_en_out       <= 1'b0;
            dest_out        <= '0;
        end else if (ready) begin
            alu_res_out     <= alu_res;
            data_memory_out <= data_d;
            mem_r_en_out    <= rd_req;
            wb_en_out       <= wb_en_in;
            dest_out        <= dest_in;
        end else begin
            mem_r_en_out    <= 1'b0;
            wb_en_out       <= 1'b0;
        end
    end

endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- Memory stage of the 5-stage ARM pipeline, directly upstream of write-back.
- Takes the EX/MEM bundle: ALU result (address or data), store value, control bits and destination.
- Performs 32-bit loads/stores on an external 16-bit-wide SRAM as two half-word accesses with wait states, stalling the pipeline through `ready`.
- Contains the MEM/WB pipeline register; its registered outputs feed write-back directly.

Parameters:
- ADDRESS_LEN, 32, data/address width (shared config constant).
- MEM_BASE, 1024, byte address mapped to SRAM word 0.
- WAIT_STATES, 5, cycles each half-word SRAM phase is held (≥1).
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alu_res  in  ADDRESS_LEN  ALU result / byte address.
- val_rm  in  ADDRESS_LEN  store data.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- wb_en_in  in  1  register write enable.
- dest_in  in  4  destination register.
- ready  out  1  high = stage accepts/completes this cycle; low freezes upstream stages.
- sram_addr  out  SRAM_AW  half-word address.
- sram_wdata  out  16  write data.
- sram_rdata  in  16  read data.
- sram_we_n  out  1  write strobe, active low.
- sram_oe_n  out  1  output enable, active low.
- alu_res_out  out  ADDRESS_LEN  registered ALU result.
- data_memory_out  out  ADDRESS_LEN  registered load data.
- mem_r_en_out  out  1  registered load flag (WB mux select).
- wb_en_out  out  1  registered write enable.
- dest_out  out  4  registered destination.

Behaviour:
- Reset:
  - FSM returns to IDLE.
  - Wait counter = 0.
  - All MEM/WB outputs = 0.
  - sram_we_n = sram_oe_n = 1; sram_addr = 0; sram_wdata = 0.
- Address mapping:
  - Word index = (alu_res − MEM_BASE) >> 2, unsigned wrap.
  - sram_addr = {word[SRAM_AW-2:0], half}; half = 0 for the low phase, 1 for the high phase.
- Non-memory op (mem_r_en = mem_w_en = 0):
  - ready = 1.
  - MEM/WB register loads the inputs at the edge; data_memory_out = 0.
  - Latency 1 cycle.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE with a request: ready = 0; go to LOW, counter = WAIT_STATES−1.
  - LOW: drives half 0.
    - Write: sram_wdata = val_rm[15:0], sram_we_n = 0.
    - Read: sram_oe_n = 0.
    - Counter decrements; at 0, a read captures sram_rdata into the low half; go to HIGH, counter reloads.
  - HIGH: same as LOW for half 1 / bits [31:16]; at 0 go to DONE.
  - DONE: ready = 1; MEM/WB register loads at this edge; go to IDLE.
- Stall timing:
  - ready is low for 1 + 2·WAIT_STATES cycles (11 at default).
  - Load data is visible on data_memory_out the cycle after DONE.
- Stall bubble: while ready = 0, MEM/WB register loads a bubble (wb_en_out = 0, mem_r_en_out = 0). Other fields hold.
- Inputs are held stable by upstream while ready = 0. The block samples alu_res/val_rm every cycle; it does not latch them.
- mem_r_en and mem_w_en both high: treated as a store; data_memory_out = 0.
- sram_we_n and sram_oe_n are never low simultaneously.
- In IDLE/DONE both strobes are high.
- Reset asserted mid-access: both strobes high after that edge; the access is abandoned and no MEM/WB load occurs.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined: an access is out of range when alu_res < MEM_BASE or word index ≥ 2^(SRAM_AW−1). An out-of-range access:
  - issues no SRAM cycle;
  - keeps ready = 1;
  - loads MEM/WB like a non-memory op with data_memory_out = 0;
  - pulses extra output mem_err (1 cycle, registered, reset 0).
- Undefined: no check, no mem_err port; addresses wrap modulo SRAM size.

Decomposition:
- Shared config/package:
  - ADDRESS_LEN;
  - FSM state encoding constants (IDLE = 0, LOW = 1, HIGH = 2, DONE = 3);
  - SRAM data width 16.
- One sub-module, sram_ctrl:
  - owns the FSM, wait counter, strobes, address and half-word assembly;
  - exposes ready and rdata32.
- Top level holds the MEM/WB register and the optional range check.

Test Plan:
- Reset mid-LOW phase of a store → next cycle sram_we_n = 1, ready = 1, all MEM/WB outputs 0.
- Non-memory op: alu_res = 0x55, wb_en_in = 1, dest_in = 3 → next cycle alu_res_out = 0x55, wb_en_out = 1, dest_out = 3, ready never low.
- Store: alu_res = 1028, val_rm = 0xDEADBEEF, WAIT_STATES = 5 →
  - sram_addr 2 with wdata 0xBEEF, we_n low 5 cycles;
  - then sram_addr 3 with wdata 0xDEAD, we_n low 5 cycles;
  - ready low exactly 11 cycles.
- Load back from 1028, SRAM model returning the stored halves → data_memory_out = 0xDEADBEEF and mem_r_en_out = 1 the cycle after DONE; wb_en_out = 0 during all stall cycles.
- Both mem_r_en and mem_w_en set, val_rm = 0x12345678 at 1024 → write cycles only, oe_n stays high, data_memory_out = 0.
- MEM_ADDR_CHECK_EN defined, load at alu_res = 16 → no strobe activity, ready stays 1, mem_err pulses 1 cycle, data_memory_out = 0.
